// File: rtl/mul_reservation_station_if.sv
// Issue, common-data-bus and multiplier-dispatch signals of the multiply reservation station.
// The station connects through the slave modport; the issue/CDB/FU driver connects through the master modport.
interface mul_reservation_station_if;
    logic        issueEN;
    logic [1:0]  issueOp;
    logic [31:0] issueVj;
    logic [3:0]  issueQj;
    logic [31:0] issueVk;
    logic [3:0]  issueQk;
    logic        issueFull;
    logic [3:0]  issueLabel;
    logic        cdbValid;
    logic [3:0]  cdbLabel;
    logic [31:0] cdbData;
    logic        fuAvailable;
    logic        fuWEN;
    logic [31:0] fuData1;
    logic [31:0] fuData2;
    logic [3:0]  fuLabel;
    logic [1:0]  fuOp;
    logic [1:0]  busyCount;

    modport master (
        output issueEN, issueOp, issueVj, issueQj, issueVk, issueQk,
        output cdbValid, cdbLabel, cdbData, fuAvailable,
        input  issueFull, issueLabel, fuWEN, fuData1, fuData2, fuLabel, fuOp, busyCount
    );

    modport slave (
        input  issueEN, issueOp, issueVj, issueQj, issueVk, issueQk,
        input  cdbValid, cdbLabel, cdbData, fuAvailable,
        output issueFull, issueLabel, fuWEN, fuData1, fuData2, fuLabel, fuOp, busyCount
    );
endinterface

// File: rtl/mul_reservation_station.sv
// Three-entry reservation station for the multiplier: captures issued operands, waits on CDB
// tags, dispatches the lowest-index ready entry and frees it when its own result is broadcast.
module mul_reservation_station #(
    parameter logic [3:0] LABEL_BASE = 4'd4
) (
    input logic                     clk,
    input logic                     nRST,
    mul_reservation_station_if.slave rs
);
    localparam int unsigned N_ENTRY = 3;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic [1:0] {FREE, WAIT, READY, DISPATCHED} state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] vj;
        logic [TAG_W-1:0]  qj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qk;
    } entry_t;

    state_t             state_q [N_ENTRY];
    state_t             state_d [N_ENTRY];
    entry_t             entry_q [N_ENTRY];
    entry_t             entry_d [N_ENTRY];
    logic [1:0]         busy_q;
    logic [1:0]         busy_d;

    logic               alloc_found;
    logic [IDX_W-1:0]   alloc_idx;
    logic               ready_found;
    logic [IDX_W-1:0]   ready_idx;
    logic               issue_go;
    logic               fu_wen;
    logic               bypass_j;
    logic               bypass_k;
    entry_t             issue_entry;

    function automatic logic [TAG_W-1:0] tag_of(input int unsigned idx);
        return LABEL_BASE + TAG_W'(idx);
    endfunction

    // Lowest-index FREE entry for allocation, lowest-index READY entry for dispatch.
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        ready_found = 1'b0;
        ready_idx   = '0;
        for (int unsigned i = 0; i < N_ENTRY; i++) begin
            if (!alloc_found && state_q[i] == FREE) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
            if (!ready_found && state_q[i] == READY) begin
                ready_found = 1'b1;
                ready_idx   = IDX_W'(i);
            end
        end
    end

    // Operands being issued may be resolved by a broadcast in the same cycle.
    always_comb begin
        bypass_j = rs.cdbValid && (rs.issueQj != '0) && (rs.cdbLabel == rs.issueQj);
        bypass_k = rs.cdbValid && (rs.issueQk != '0) && (rs.cdbLabel == rs.issueQk);
        issue_entry.op = rs.issueOp;
        issue_entry.vj = bypass_j ? rs.cdbData : rs.issueVj;
        issue_entry.qj = bypass_j ? '0 : rs.issueQj;
        issue_entry.vk = bypass_k ? rs.cdbData : rs.issueVk;
        issue_entry.qk = bypass_k ? '0 : rs.issueQk;
    end

    assign issue_go = rs.issueEN && alloc_found;
    assign fu_wen   = rs.fuAvailable && ready_found;

    assign rs.issueFull  = !alloc_found;
    assign rs.issueLabel = alloc_found ? tag_of(32'(alloc_idx)) : LABEL_BASE;
    assign rs.fuWEN      = fu_wen;
    assign rs.fuData1    = ready_found ? entry_q[ready_idx].vj : '0;
    assign rs.fuData2    = ready_found ? entry_q[ready_idx].vk : '0;
    assign rs.fuLabel    = ready_found ? tag_of(32'(ready_idx)) : '0;
    assign rs.fuOp       = ready_found ? entry_q[ready_idx].op : '0;
    assign rs.busyCount  = busy_q;

    // Per-entry next state; a READY entry only becomes visible for dispatch after its edge.
    always_comb begin
        busy_d = '0;
        for (int unsigned i = 0; i < N_ENTRY; i++) begin
            state_d[i] = state_q[i];
            entry_d[i] = entry_q[i];
            case (state_q[i])
                FREE: begin
                    if (issue_go && alloc_idx == IDX_W'(i)) begin
                        entry_d[i] = issue_entry;
                        state_d[i] = (issue_entry.qj == '0 && issue_entry.qk == '0) ? READY : WAIT;
                    end
                end
                WAIT: begin
                    if (rs.cdbValid && entry_q[i].qj != '0 && rs.cdbLabel == entry_q[i].qj) begin
                        entry_d[i].vj = rs.cdbData;
                        entry_d[i].qj = '0;
                    end
                    if (rs.cdbValid && entry_q[i].qk != '0 && rs.cdbLabel == entry_q[i].qk) begin
                        entry_d[i].vk = rs.cdbData;
                        entry_d[i].qk = '0;
                    end
                    if (entry_d[i].qj == '0 && entry_d[i].qk == '0) begin
                        state_d[i] = READY;
                    end
                end
                READY: begin
                    if (fu_wen && ready_idx == IDX_W'(i)) begin
                        state_d[i] = DISPATCHED;
                    end
                end
                DISPATCHED: begin
                    if (rs.cdbValid && rs.cdbLabel == tag_of(i)) begin
                        state_d[i] = FREE;
                    end
                end
                default: state_d[i] = FREE;
            endcase
            if (state_d[i] != FREE) begin
                busy_d = busy_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < N_ENTRY; i++) begin
                state_q[i] <= FREE;
                entry_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_ENTRY; i++) begin
                state_q[i] <= state_d[i];
                entry_q[i] <= entry_d[i];
            end
            busy_q <= busy_d;
        end
    end
endmodule
